// File: rtl/i2c_slave_sda_gen_pkg.sv
// ----------------------------------------------------------------------------
// i2c_slave_pkg : shared types and constants for the i2c_slave_sda_gen slice
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package i2c_slave_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ADDR      = 3'd1,
    ADDR_ACK  = 3'd2,
    TX_BYTE   = 3'd3,
    TX_MACK   = 3'd4,
    RX_BYTE   = 3'd5,
    RX_ACK    = 3'd6,
    WAIT_STOP = 3'd7
  } state_t;

  localparam logic [6:0] SLAVE_ADDR_DEFAULT = 7'h5B;
  localparam logic [6:0] GENERAL_CALL_ADDR  = 7'h00;
  localparam int         BYTES_PER_XFER     = 2;

endpackage

`default_nettype wire

// File: rtl/i2c_slave_sda_gen_if.sv
// ----------------------------------------------------------------------------
// i2c_slave_sda_gen_if : SCL, ACK controls and data bytes of the I2C slave
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface i2c_slave_sda_gen_if;
  logic       scl;
  logic       receive_data1_ack;
  logic       receive_data2_ack;
  logic [7:0] data1_received;
  logic [7:0] data2_received;
  logic [7:0] data1_sent;
  logic [7:0] data2_sent;

  modport slave (
    input  scl,
    input  receive_data1_ack,
    input  receive_data2_ack,
    input  data1_received,
    input  data2_received,
    output data1_sent,
    output data2_sent
  );

  modport master (
    output scl,
    output receive_data1_ack,
    output receive_data2_ack,
    output data1_received,
    output data2_received,
    input  data1_sent,
    input  data2_sent
  );
endinterface

`default_nettype wire

// File: rtl/i2c_slave_sda_gen_bus_cond_det.sv
// ----------------------------------------------------------------------------
// i2c_bus_cond_det : SCL/SDA synchronizers, SCL edge and START/STOP detection
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module i2c_bus_cond_det #(
  parameter int SYNC_STAGES = 2
) (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic i_scl,
  input  wire logic i_sda,
  output logic      o_sda,
  output logic      o_scl_rise,
  output logic      o_scl_fall,
  output logic      o_start,
  output logic      o_stop
);

  logic [SYNC_STAGES-1:0] r_scl_sync;
  logic [SYNC_STAGES-1:0] r_sda_sync;
  logic                   r_scl_prev;
  logic                   r_sda_prev;
  logic                   w_scl;
  logic                   w_sda;

  // Reset to the idle-bus level so leaving reset never looks like a START
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_prev <= 1'b1;
      r_sda_prev <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], i_scl};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], i_sda};
      r_scl_prev <= w_scl;
      r_sda_prev <= w_sda;
    end
  end

  assign w_scl      = r_scl_sync[SYNC_STAGES-1];
  assign w_sda      = r_sda_sync[SYNC_STAGES-1];
  assign o_sda      = w_sda;
  assign o_scl_rise =  w_scl & ~r_scl_prev;
  assign o_scl_fall = ~w_scl &  r_scl_prev;
  assign o_start    = w_scl & r_scl_prev &  r_sda_prev & ~w_sda;
  assign o_stop     = w_scl & r_scl_prev & ~r_sda_prev &  w_sda;

endmodule

`default_nettype wire

// File: rtl/i2c_slave_sda_gen.sv
// ----------------------------------------------------------------------------
// i2c_slave_sda_gen : two-byte I2C slave, open-drain SDA. Optional macro
// GENERAL_CALL_EN makes address 7'h00 with R/W=0 behave as a write.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module i2c_slave_sda_gen
  import i2c_slave_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR  = SLAVE_ADDR_DEFAULT,
  parameter int         SYNC_STAGES = 2
) (
  input  wire logic            clk,
  input  wire logic            rst_n,
  inout  wire                  sda_pin,
  i2c_slave_sda_gen_if.slave   bus
);

  localparam logic LAST_IDX = 1'(BYTES_PER_XFER - 1);

  state_t     r_state, state_n;
  logic [2:0] r_bit_cnt, bit_cnt_n;
  logic [6:0] r_shift, shift_n;
  logic [7:0] r_tx, tx_n;
  logic       r_idx, idx_n;
  logic       r_phase, phase_n;
  logic       r_sda_low, sda_low_n;
  logic [7:0] r_data1_sent, data1_sent_n;
  logic [7:0] r_data2_sent, data2_sent_n;

  logic       w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;
  logic [7:0] w_byte;
  logic       w_match;
  logic [7:0] w_tx_src;
  logic       w_rx_ack;

  i2c_bus_cond_det #(.SYNC_STAGES(SYNC_STAGES)) u_cond (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_scl      (bus.scl),
    .i_sda      (sda_pin),
    .o_sda      (w_sda),
    .o_scl_rise (w_scl_rise),
    .o_scl_fall (w_scl_fall),
    .o_start    (w_start),
    .o_stop     (w_stop)
  );

  assign w_byte   = {r_shift, w_sda};
  assign w_tx_src = r_idx ? bus.data2_received : bus.data1_received;
  assign w_rx_ack = r_idx ? bus.receive_data2_ack : bus.receive_data1_ack;

`ifdef GENERAL_CALL_EN
  assign w_match = (w_byte[7:1] == SLAVE_ADDR) ||
                   ((w_byte[7:1] == GENERAL_CALL_ADDR) && !w_byte[0]);
`else
  assign w_match = (w_byte[7:1] == SLAVE_ADDR);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_bit_cnt    <= 3'd0;
      r_shift      <= 7'd0;
      r_tx         <= 8'd0;
      r_idx        <= 1'b0;
      r_phase      <= 1'b0;
      r_sda_low    <= 1'b0;
      r_data1_sent <= 8'h00;
      r_data2_sent <= 8'h00;
    end else begin
      r_state      <= state_n;
      r_bit_cnt    <= bit_cnt_n;
      r_shift      <= shift_n;
      r_tx         <= tx_n;
      r_idx        <= idx_n;
      r_phase      <= phase_n;
      r_sda_low    <= sda_low_n;
      r_data1_sent <= data1_sent_n;
      r_data2_sent <= data2_sent_n;
    end
  end

  // r_phase splits each 9th-clock state: 0 = before the ACK slot, 1 = inside it
  always_comb begin
    state_n      = r_state;
    bit_cnt_n    = r_bit_cnt;
    shift_n      = r_shift;
    tx_n         = r_tx;
    idx_n        = r_idx;
    phase_n      = r_phase;
    sda_low_n    = r_sda_low;
    data1_sent_n = r_data1_sent;
    data2_sent_n = r_data2_sent;

    if (w_stop) begin
      state_n   = IDLE;
      sda_low_n = 1'b0;
    end else if (w_start) begin
      state_n   = ADDR;
      bit_cnt_n = 3'd0;
      idx_n     = 1'b0;
      phase_n   = 1'b0;
      sda_low_n = 1'b0;
    end else begin
      case (r_state)
        ADDR: if (w_scl_rise) begin
          shift_n   = w_byte[6:0];
          bit_cnt_n = r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) begin
            state_n = w_match ? ADDR_ACK : WAIT_STOP;
            phase_n = 1'b0;
          end
        end
        ADDR_ACK: if (w_scl_fall) begin
          if (!r_phase) begin
            sda_low_n = 1'b1;
            phase_n   = 1'b1;
          end else begin
            phase_n   = 1'b0;
            bit_cnt_n = 3'd0;
            if (r_shift[0]) begin
              state_n   = TX_BYTE;
              tx_n      = w_tx_src;
              sda_low_n = ~w_tx_src[7];
            end else begin
              state_n   = RX_BYTE;
              sda_low_n = 1'b0;
            end
          end
        end
        TX_BYTE: if (w_scl_fall) begin
          if (r_bit_cnt == 3'd7) begin
            state_n   = TX_MACK;
            sda_low_n = 1'b0;
            bit_cnt_n = 3'd0;
            phase_n   = 1'b0;
          end else begin
            bit_cnt_n = r_bit_cnt + 3'd1;
            tx_n      = {r_tx[6:0], 1'b0};
            sda_low_n = ~r_tx[6];
          end
        end
        TX_MACK: begin
          if (w_scl_rise) begin
            if (!w_sda && (r_idx != LAST_IDX)) begin
              phase_n = 1'b1;
              idx_n   = r_idx + 1'b1;
            end else begin
              state_n = WAIT_STOP;
            end
          end else if (w_scl_fall && r_phase) begin
            state_n   = TX_BYTE;
            phase_n   = 1'b0;
            bit_cnt_n = 3'd0;
            tx_n      = w_tx_src;
            sda_low_n = ~w_tx_src[7];
          end
        end
        RX_BYTE: if (w_scl_rise) begin
          shift_n   = w_byte[6:0];
          bit_cnt_n = r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) begin
            if (r_idx) data2_sent_n = w_byte;
            else       data1_sent_n = w_byte;
            state_n = RX_ACK;
            phase_n = 1'b0;
          end
        end
        RX_ACK: if (w_scl_fall) begin
          if (!r_phase) begin
            sda_low_n = w_rx_ack;
            phase_n   = 1'b1;
          end else begin
            sda_low_n = 1'b0;
            phase_n   = 1'b0;
            bit_cnt_n = 3'd0;
            if (r_idx == LAST_IDX) begin
              state_n = WAIT_STOP;
            end else begin
              state_n = RX_BYTE;
              idx_n   = r_idx + 1'b1;
            end
          end
        end
        WAIT_STOP: sda_low_n = 1'b0;
        default:   sda_low_n = 1'b0;
      endcase
    end
  end

  assign sda_pin        = r_sda_low ? 1'b0 : 1'bz;
  assign bus.data1_sent = r_data1_sent;
  assign bus.data2_sent = r_data2_sent;

endmodule

`default_nettype wire

// File: tb/tb_i2c_slave_sda_gen.sv
// ----------------------------------------------------------------------------
// tb_i2c_slave_sda_gen : directed master-side bench for i2c_slave_sda_gen
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_i2c_slave_sda_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic m_sda_low = 1'b0;
  wire  sda_pin;
  int   n_checks = 0;
  int   n_fail = 0;

  i2c_slave_sda_gen_if bus_if ();

  pullup (sda_pin);
  assign sda_pin = m_sda_low ? 1'b0 : 1'bz;

  i2c_slave_sda_gen #(.SLAVE_ADDR(7'h5B), .SYNC_STAGES(2)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .sda_pin (sda_pin),
    .bus     (bus_if)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One SCL period of 16 clk; returns the SDA level seen mid-high
  task automatic m_bit(input logic b, output logic s);
    tick(1); m_sda_low = ~b;
    tick(3); bus_if.scl = 1'b1;
    tick(4); s = sda_pin;
    tick(4); bus_if.scl = 1'b0;
    tick(4);
  endtask

  task automatic m_start();
    if (bus_if.scl == 1'b0) begin
      tick(1); m_sda_low = 1'b0;
      tick(3); bus_if.scl = 1'b1;
      tick(4);
    end
    m_sda_low = 1'b1;
    tick(4); bus_if.scl = 1'b0;
    tick(4);
  endtask

  task automatic m_stop();
    tick(1); m_sda_low = 1'b1;
    tick(3); bus_if.scl = 1'b1;
    tick(4); m_sda_low = 1'b0;
    tick(8);
  endtask

  task automatic m_byte(input logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) m_bit(b[i], s);
  endtask

  task automatic m_read(output logic [7:0] d);
    logic s;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      m_bit(1'b1, s);
      d = {d[6:0], s};
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bus_if.scl = 1'b1; m_sda_low = 1'b0;
    bus_if.receive_data1_ack = 1'b1; bus_if.receive_data2_ack = 1'b1;
    bus_if.data1_received = 8'h00; bus_if.data2_received = 8'h00;
    tick(3);
    n_checks++; if (sda_pin !== 1'b1) begin n_fail++; $display("FAIL reset_sda got %b exp 1", sda_pin); end
    n_checks++; if (bus_if.data1_sent !== 8'h00) begin n_fail++; $display("FAIL reset_d1 got %h exp 00", bus_if.data1_sent); end
    n_checks++; if (bus_if.data2_sent !== 8'h00) begin n_fail++; $display("FAIL reset_d2 got %h exp 00", bus_if.data2_sent); end
    rst_n = 1'b1;
    tick(4);
  endtask

  task automatic test_read();
    logic s; logic [7:0] d;
    bus_if.data1_received = 8'hA8; bus_if.data2_received = 8'h39;
    m_start(); m_byte(8'hB7);
    m_bit(1'b1, s);
    n_checks++; if (s !== 1'b0) begin n_fail++; $display("FAIL read_addr_ack got %b exp 0", s); end
    m_read(d);
    n_checks++; if (d !== 8'hA8) begin n_fail++; $display("FAIL read_byte1 got %h exp a8", d); end
    m_bit(1'b0, s);
    m_read(d);
    n_checks++; if (d !== 8'h39) begin n_fail++; $display("FAIL read_byte2 got %h exp 39", d); end
    m_bit(1'b0, s);
    m_stop();
    n_checks++; if (sda_pin !== 1'b1) begin n_fail++; $display("FAIL read_release got %b exp 1", sda_pin); end
  endtask

  task automatic test_write(input logic [7:0] b1, input logic [7:0] b2, input logic a1, input logic a2);
    logic s;
    bus_if.receive_data1_ack = a1; bus_if.receive_data2_ack = a2;
    m_start(); m_byte(8'hB6);
    m_bit(1'b1, s);
    n_checks++; if (s !== 1'b0) begin n_fail++; $display("FAIL write_addr_ack got %b exp 0", s); end
    m_byte(b1); m_bit(1'b1, s);
    n_checks++; if (s !== ~a1) begin n_fail++; $display("FAIL write_ack1 got %b exp %b", s, ~a1); end
    m_byte(b2); m_bit(1'b1, s);
    n_checks++; if (s !== ~a2) begin n_fail++; $display("FAIL write_ack2 got %b exp %b", s, ~a2); end
    m_stop();
    n_checks++; if (bus_if.data1_sent !== b1) begin n_fail++; $display("FAIL write_d1 got %h exp %h", bus_if.data1_sent, b1); end
    n_checks++; if (bus_if.data2_sent !== b2) begin n_fail++; $display("FAIL write_d2 got %h exp %h", bus_if.data2_sent, b2); end
    bus_if.receive_data1_ack = 1'b1; bus_if.receive_data2_ack = 1'b1;
  endtask

  task automatic test_mismatch();
    logic s; logic [7:0] d;
    bus_if.data1_received = 8'h00; bus_if.data2_received = 8'h00;
    m_start(); m_byte(8'hB5);
    m_bit(1'b1, s);
    n_checks++; if (s !== 1'b1) begin n_fail++; $display("FAIL mismatch_ack got %b exp 1", s); end
    m_read(d);
    n_checks++; if (d !== 8'hFF) begin n_fail++; $display("FAIL mismatch_bus got %h exp ff", d); end
    m_stop();
    n_checks++; if (bus_if.data1_sent !== 8'h3C) begin n_fail++; $display("FAIL mismatch_d1 got %h exp 3c", bus_if.data1_sent); end
    n_checks++; if (bus_if.data2_sent !== 8'hC3) begin n_fail++; $display("FAIL mismatch_d2 got %h exp c3", bus_if.data2_sent); end
  endtask

  task automatic test_master_nack();
    logic s; logic [7:0] d;
    bus_if.data1_received = 8'h00; bus_if.data2_received = 8'h00;
    m_start(); m_byte(8'hB7);
    m_bit(1'b1, s);
    n_checks++; if (s !== 1'b0) begin n_fail++; $display("FAIL nack_addr_ack got %b exp 0", s); end
    m_read(d);
    n_checks++; if (d !== 8'h00) begin n_fail++; $display("FAIL nack_byte1 got %h exp 00", d); end
    m_bit(1'b1, s);
    m_read(d);
    n_checks++; if (d !== 8'hFF) begin n_fail++; $display("FAIL nack_no_byte2 got %h exp ff", d); end
    m_stop();
  endtask

  task automatic test_repeated_start();
    logic s;
    m_start();
    m_bit(1'b1, s); m_bit(1'b0, s); m_bit(1'b1, s); m_bit(1'b1, s);
    test_write(8'h12, 8'h34, 1'b1, 1'b1);
  endtask

  task automatic test_reset_mid_tx();
    logic s;
    bus_if.data1_received = 8'h00;
    m_start(); m_byte(8'hB7);
    m_bit(1'b1, s);
    n_checks++; if (sda_pin !== 1'b0) begin n_fail++; $display("FAIL midtx_driving got %b exp 0", sda_pin); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (sda_pin !== 1'b1) begin n_fail++; $display("FAIL midtx_release got %b exp 1", sda_pin); end
    n_checks++; if (bus_if.data1_sent !== 8'h00) begin n_fail++; $display("FAIL midtx_d1 got %h exp 00", bus_if.data1_sent); end
    n_checks++; if (bus_if.data2_sent !== 8'h00) begin n_fail++; $display("FAIL midtx_d2 got %h exp 00", bus_if.data2_sent); end
    tick(2);
    bus_if.scl = 1'b1; m_sda_low = 1'b0; rst_n = 1'b1;
    tick(8);
  endtask

  initial begin
    test_reset();
    test_read();
    test_write(8'h3C, 8'hC3, 1'b1, 1'b1);
    test_mismatch();
    test_write(8'hA5, 8'h5A, 1'b1, 1'b1);
    test_master_nack();
    test_write(8'h81, 8'h7E, 1'b1, 1'b0);
    test_repeated_start();
    test_reset_mid_tx();
    test_write(8'h96, 8'h69, 1'b1, 1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
